cpu_wb_master_bridge: RTL and testbench
=======================================

Name: cpu_wb_master_bridge

Overview:
- Wishbone master that sits directly upstream of the SoC interconnect.
- Converts single CPU load/store requests into pipelined Wishbone B4 cycles that drive the interconnect's i_wb_* / re / we inputs.
- Performs byte-lane steering, load sign/zero extension and misalignment checks, and returns one response per request.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (only 32 is supported)
- TIMEOUT_CYCLES, 255, cycles of cyc without ack before an error (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cpu_req  in  1  request valid; held until accepted
- cpu_ready  out  1  bridge idle and able to accept (combinational from state)
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- cpu_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data, right-justified
- cpu_done  out  1  one-cycle response pulse
- cpu_rdata  out  DATA_W  extended load data; valid with cpu_done
- cpu_err  out  1  with cpu_done: misaligned access or timeout
- o_wb_cyc  out  1  to interconnect i_wb_cyc
- o_wb_stb  out  1  to interconnect i_wb_stb
- o_wb_sel  out  4  byte enables
- o_wb_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- o_wb_data  out  DATA_W  lane-replicated write data
- o_re  out  1  read strobe (high with cyc on loads)
- o_we  out  1  write strobe (high with cyc on stores)
- i_wb_data  in  DATA_W  read data from interconnect
- i_wb_ack  in  1  ack
- i_wb_stall  in  1  stall

Behaviour:
- Reset (async): state IDLE; all o_wb_*, o_re, o_we, cpu_done, cpu_err = 0; cpu_rdata = 0; timeout counter = 0.
- All Wishbone outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE
  - cpu_ready = 1.
  - On cpu_req: latch addr, size, we, unsigned flag and wdata.
  - Misalignment is defined as: half with addr[0] = 1, word with addr[1:0] != 0, or size = 11.
  - Misaligned -> RESP with err = 1; no bus cycle is started.
  - Otherwise -> REQ.
- REQ
  - cyc = stb = 1; re or we set per cpu_we.
  - If i_wb_stall = 0 this cycle -> drop stb next cycle and go to WAIT.
  - An ack sampled while in REQ with stall = 0 completes the transfer immediately (ack in the same cycle as acceptance).
- WAIT
  - cyc = 1, stb = 0.
  - On i_wb_ack: capture data, drop cyc/re/we, go to RESP.
- RESP
  - cpu_done = 1 for exactly one cycle, then IDLE.
- Latency: request accepted at cycle 0, cyc/stb high at cycle 1. With zero stall and ack at cycle N, cpu_done is asserted at cycle N+1. A misaligned request gives cpu_done at cycle 1.
- sel / data steering:
  - Byte: sel = 1 << addr[1:0]; o_wb_data = {4{wdata[7:0]}}.
  - Half: sel = addr[1] ? 1100 : 0011; o_wb_data = {2{wdata[15:0]}}.
  - Word: sel = 1111.
  - o_wb_sel is driven on loads as well.
- Load return: extract the lane selected by addr[1:0] and size, then sign- or zero-extend to 32 bits. Stores return cpu_rdata = 0.
- i_wb_ack while cyc = 0 is ignored. A second ack is ignored because cyc drops the cycle after the first.
- cpu_req while not ready is ignored (no queueing). The CPU must hold its request.
- Reset asserted mid-transaction: cyc/stb drop immediately and asynchronously; no cpu_done is issued.

Optional Feature:
- Macro: WB_BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES with no ack: drop cyc/stb and go to RESP with cpu_err = 1 and cpu_rdata = 0.
  - Ack in the same cycle as the timeout wins (normal completion).
- Undefined: no counter is built, and the bridge waits indefinitely for ack.

Decomposition:
- Shared package (soc_bus_pkg):
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD
  - state enum constants
  - DATA_W / ADDR_W defaults
- One sub-module, wb_lane_steer: purely combinational.
  - Inputs: size and addr[1:0].
  - Outputs: sel, replicated wdata, and extended rdata.
  - Reused by future masters (e.g. DMA).

Test Plan:
- Word store at 0x0000_0010, data 0xCAFEBABE, ack 1 cycle after stb → o_wb_sel = 1111, o_we = 1, o_wb_addr = 0x10, cpu_done with err = 0 two cycles after the ack cycle... specifically exactly one cycle after ack, then cyc = 0.
- Byte load at 0x13, bus returns 0x80FF_0000, signed → sel = 1000, cpu_rdata = 0xFFFF_FF80. Same access unsigned → 0x0000_0080.
- Half load at 0x12 with i_wb_stall held high for 3 cycles → stb stays high for 4 cycles, sel = 1100. Bus returns 0x8001_xxxx signed → cpu_rdata = 0xFFFF_8001.
- Word access at 0x02, and half access at 0x01 → no cyc ever asserted; cpu_done with err = 1 at cycle 1.
- rst pulsed while in WAIT → cyc/stb/re/we = 0 immediately; no cpu_done; next request completes normally.
- With WB_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no ack → cyc drops after 8 cycles, cpu_err = 1, cpu_rdata = 0. A late ack afterwards is ignored.

Source files
------------

// File: rtl/soc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_bus_pkg
// Description : Shared encodings for SoC bus masters. It holds the access
//               size codes, the master FSM states, bus width defaults and
//               the misalignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_bus_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // CPU access size encodings
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Bus master transaction states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // An access is misaligned if it is a half on an odd byte address, a word
   // that is not on a 4-byte boundary, or it uses the reserved size code.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic r;
      r = 1'b0;
      case (size)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = addr_lo[0];
         SZ_WORD: r = (addr_lo != 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : wb_lane_steer
// Description : Combinational byte-lane steering for a 32-bit Wishbone
//               master. It produces the byte enables and the lane-replicated
//               write data, and extracts and extends the load data.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_lane_steer
   import soc_bus_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] bus_rdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] w_shifted;
   logic [15:0] w_half;

   assign w_shifted = bus_rdata_i >> {addr_lo_i, 3'b000};
   assign w_half    = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

   // Byte enables and write data replication. Each lane carries the data a
   // slave expects, whichever lane it decodes.
   always_comb begin
      sel_o   = 4'b0000;
      wdata_o = 32'h0;
      case (size_i)
         SZ_BYTE: begin
            sel_o   = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
         end
         SZ_WORD: begin
            sel_o   = 4'b1111;
            wdata_o = wdata_i;
         end
         default: begin
            sel_o   = 4'b0000;
            wdata_o = 32'h0;
         end
      endcase
   end

   // Load lane extraction followed by sign or zero extension
   always_comb begin
      rdata_o = 32'h0;
      case (size_i)
         SZ_BYTE: rdata_o = {{24{~uns_i & w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: rdata_o = {{16{~uns_i & w_half[15]}}, w_half};
         SZ_WORD: rdata_o = bus_rdata_i;
         default: rdata_o = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cpu_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_master_bridge
// Description : Single-outstanding CPU load/store to pipelined Wishbone B4
//               master. It handles byte-lane steering, load extension and
//               misalignment rejection, and gives one response per request.
//               Optional macro WB_BUS_TIMEOUT_EN adds a bus timeout that
//               completes a stuck cycle with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_wb_master_bridge
   import soc_bus_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   output logic              cpu_ready,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_size,
   input  logic              cpu_unsigned,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic [3:0]        o_wb_sel,
   output logic [ADDR_W-1:0] o_wb_addr,
   output logic [DATA_W-1:0] o_wb_data,
   output logic              o_re,
   output logic              o_we,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic              i_wb_ack,
   input  logic              i_wb_stall
);

   state_t            state_q;
   logic [1:0]        addr_lo_q;
   logic [1:0]        size_q;
   logic              we_q;
   logic              uns_q;
   logic              cyc_q;
   logic              stb_q;
   logic [3:0]        sel_q;
   logic [ADDR_W-1:0] wbaddr_q;
   logic [DATA_W-1:0] wbdata_q;
   logic              re_q;
   logic              wbwe_q;
   logic              done_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;

   logic              w_idle;
   logic              w_busy;
   logic              w_misaligned;
   logic              w_accept;
   logic              w_ack_take;
   logic              w_to_hit;
   logic              w_timeout;
   logic [1:0]        w_size;
   logic [1:0]        w_addr_lo;
   logic              w_uns;
   logic [3:0]        w_sel;
   logic [31:0]       w_wdata_rep;
   logic [31:0]       w_rdata_ext;

   assign w_idle       = (state_q == ST_IDLE);
   assign w_busy       = (state_q == ST_REQ) || (state_q == ST_WAIT);
   assign w_misaligned = is_misaligned(cpu_size, cpu_addr[1:0]);
   assign w_accept     = w_idle && cpu_req;

   // An ack only counts once the strobe has been accepted by the slave:
   // either in WAIT, or in REQ in the same cycle the stall is low.
   assign w_ack_take = i_wb_ack &&
                       ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !i_wb_stall));
   assign w_timeout  = w_busy && w_to_hit && !w_ack_take;

   // While idle the steering looks at the live request so the bus outputs
   // can be registered at acceptance; afterwards it sees the latched fields.
   assign w_size    = w_idle ? cpu_size       : size_q;
   assign w_addr_lo = w_idle ? cpu_addr[1:0]  : addr_lo_q;
   assign w_uns     = w_idle ? cpu_unsigned   : uns_q;

   wb_lane_steer u_steer (
      .size_i      (w_size),
      .addr_lo_i   (w_addr_lo),
      .uns_i       (w_uns),
      .wdata_i     (cpu_wdata),
      .bus_rdata_i (i_wb_data),
      .sel_o       (w_sel),
      .wdata_o     (w_wdata_rep),
      .rdata_o     (w_rdata_ext)
   );

`ifdef WB_BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;

   assign w_to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Cycle counter for the current bus cycle, restarted on every new cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (w_accept && !w_misaligned) begin
         to_cnt_q <= '0;
      end else if (w_busy) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   logic w_unused_to;
   assign w_unused_to = (TIMEOUT_CYCLES != 0);
   assign w_to_hit    = 1'b0;
`endif

   // Transaction FSM with all bus and response outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_lo_q <= 2'b00;
         size_q    <= SZ_BYTE;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         sel_q     <= 4'b0000;
         wbaddr_q  <= '0;
         wbdata_q  <= '0;
         re_q      <= 1'b0;
         wbwe_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cpu_req) begin
                  addr_lo_q <= cpu_addr[1:0];
                  size_q    <= cpu_size;
                  we_q      <= cpu_we;
                  uns_q     <= cpu_unsigned;
                  if (w_misaligned) begin
                     state_q <= ST_RESP;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     state_q  <= ST_REQ;
                     cyc_q    <= 1'b1;
                     stb_q    <= 1'b1;
                     re_q     <= ~cpu_we;
                     wbwe_q   <= cpu_we;
                     sel_q    <= w_sel;
                     wbaddr_q <= {cpu_addr[ADDR_W-1:2], 2'b00};
                     wbdata_q <= w_wdata_rep;
                  end
               end
            end
            ST_REQ, ST_WAIT: begin
               if ((state_q == ST_REQ) && !i_wb_stall) begin
                  stb_q   <= 1'b0;
                  state_q <= ST_WAIT;
               end
               if (w_ack_take) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  re_q    <= 1'b0;
                  wbwe_q  <= 1'b0;
                  state_q <= ST_RESP;
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
                  rdata_q <= we_q ? '0 : w_rdata_ext;
               end else if (w_timeout) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  re_q    <= 1'b0;
                  wbwe_q  <= 1'b0;
                  state_q <= ST_RESP;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            ST_RESP: begin
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cpu_ready = w_idle;
   assign cpu_done  = done_q;
   assign cpu_err   = err_q;
   assign cpu_rdata = rdata_q;
   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = stb_q;
   assign o_wb_sel  = sel_q;
   assign o_wb_addr = wbaddr_q;
   assign o_wb_data = wbdata_q;
   assign o_re      = re_q;
   assign o_we      = wbwe_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_wb_master_bridge
// Description : Directed self-checking bench for cpu_wb_master_bridge.
//               Covers the WB_BUS_TIMEOUT_EN scenario when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_wb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_ready;
   logic        cpu_we;
   logic [1:0]  cpu_size;
   logic        cpu_unsigned;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic        o_re;
   logic        o_we;
   logic [31:0] i_wb_data;
   logic        i_wb_ack;
   logic        i_wb_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_wb_master_bridge #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req      (cpu_req),
      .cpu_ready    (cpu_ready),
      .cpu_we       (cpu_we),
      .cpu_size     (cpu_size),
      .cpu_unsigned (cpu_unsigned),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_done     (cpu_done),
      .cpu_rdata    (cpu_rdata),
      .cpu_err      (cpu_err),
      .o_wb_cyc     (o_wb_cyc),
      .o_wb_stb     (o_wb_stb),
      .o_wb_sel     (o_wb_sel),
      .o_wb_addr    (o_wb_addr),
      .o_wb_data    (o_wb_data),
      .o_re         (o_re),
      .o_we         (o_we),
      .i_wb_data    (i_wb_data),
      .i_wb_ack     (i_wb_ack),
      .i_wb_stall   (i_wb_stall)
   );

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for one clock; returns just after the accepting edge
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      cpu_we       = we;
      cpu_size     = sz;
      cpu_unsigned = uns;
      cpu_addr     = addr;
      cpu_wdata    = wd;
      cpu_req      = 1'b1;
      tick();
      cpu_req      = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
      cpu_unsigned = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      i_wb_data = '0; i_wb_ack = 1'b0; i_wb_stall = 1'b0;
      #12;
      chk("rst_cyc",   {31'b0, o_wb_cyc},  32'h0);
      chk("rst_stb",   {31'b0, o_wb_stb},  32'h0);
      chk("rst_done",  {31'b0, cpu_done},  32'h0);
      chk("rst_rdata", cpu_rdata,          32'h0);
      chk("rst_ready", {31'b0, cpu_ready}, 32'h1);
      rst = 1'b0;
      tick();

      // Word store at 0x10, ack one cycle after stb
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hCAFE_BABE);
      chk("ws_cyc",   {31'b0, o_wb_cyc},  32'h1);
      chk("ws_stb",   {31'b0, o_wb_stb},  32'h1);
      chk("ws_we",    {31'b0, o_we},      32'h1);
      chk("ws_re",    {31'b0, o_re},      32'h0);
      chk("ws_sel",   {28'b0, o_wb_sel},  32'hF);
      chk("ws_addr",  o_wb_addr,          32'h10);
      chk("ws_data",  o_wb_data,          32'hCAFE_BABE);
      chk("ws_ready", {31'b0, cpu_ready}, 32'h0);
      tick();
      chk("ws_wait_stb", {31'b0, o_wb_stb}, 32'h0);
      chk("ws_wait_cyc", {31'b0, o_wb_cyc}, 32'h1);
      chk("ws_wait_done", {31'b0, cpu_done}, 32'h0);
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      chk("ws_done",  {31'b0, cpu_done}, 32'h1);
      chk("ws_err",   {31'b0, cpu_err},  32'h0);
      chk("ws_cyc0",  {31'b0, o_wb_cyc}, 32'h0);
      chk("ws_we0",   {31'b0, o_we},     32'h0);
      chk("ws_rdata", cpu_rdata,         32'h0);
      tick();
      chk("ws_done1", {31'b0, cpu_done},  32'h0);
      chk("ws_ready1", {31'b0, cpu_ready}, 32'h1);

      // Byte load at 0x13, signed, ack in the acceptance cycle
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
      chk("bl_sel",  {28'b0, o_wb_sel}, 32'h8);
      chk("bl_re",   {31'b0, o_re},     32'h1);
      chk("bl_addr", o_wb_addr,         32'h10);
      i_wb_ack = 1'b1; i_wb_data = 32'h80FF_0000;
      tick();
      i_wb_ack = 1'b0;
      chk("bl_done",  {31'b0, cpu_done}, 32'h1);
      chk("bl_rdata", cpu_rdata,         32'hFFFF_FF80);
      chk("bl_cyc0",  {31'b0, o_wb_cyc}, 32'h0);
      tick();

      // Same byte load, unsigned
      issue(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      chk("blu_done",  {31'b0, cpu_done}, 32'h1);
      chk("blu_rdata", cpu_rdata,         32'h0000_0080);
      tick();

      // Half load at 0x12 with stall held for three cycles
      i_wb_stall = 1'b1;
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0);
      chk("hl_stb1", {31'b0, o_wb_stb}, 32'h1);
      chk("hl_sel",  {28'b0, o_wb_sel}, 32'hC);
      tick();
      chk("hl_stb2", {31'b0, o_wb_stb}, 32'h1);
      tick();
      chk("hl_stb3", {31'b0, o_wb_stb}, 32'h1);
      tick();
      chk("hl_stb4", {31'b0, o_wb_stb}, 32'h1);
      i_wb_stall = 1'b0;
      tick();
      chk("hl_stb_drop", {31'b0, o_wb_stb}, 32'h0);
      chk("hl_cyc",      {31'b0, o_wb_cyc}, 32'h1);
      i_wb_ack = 1'b1; i_wb_data = 32'h8001_1234;
      tick();
      i_wb_ack = 1'b0;
      chk("hl_done",  {31'b0, cpu_done}, 32'h1);
      chk("hl_rdata", cpu_rdata,         32'hFFFF_8001);
      tick();

      // Byte store at 0x05 and half store at 0x06: lane replication
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_56A5);
      chk("bs_sel",  {28'b0, o_wb_sel}, 32'h2);
      chk("bs_data", o_wb_data,         32'hA5A5_A5A5);
      chk("bs_addr", o_wb_addr,         32'h4);
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      tick();
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_BEEF);
      chk("hs_sel",  {28'b0, o_wb_sel}, 32'hC);
      chk("hs_data", o_wb_data,         32'hBEEF_BEEF);
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      chk("hs_done", {31'b0, cpu_done}, 32'h1);
      tick();

      // Misaligned word at 0x02 and half at 0x01: error, no bus cycle
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
      chk("mw_done", {31'b0, cpu_done}, 32'h1);
      chk("mw_err",  {31'b0, cpu_err},  32'h1);
      chk("mw_cyc",  {31'b0, o_wb_cyc}, 32'h0);
      tick();
      chk("mw_cyc2", {31'b0, o_wb_cyc}, 32'h0);
      chk("mw_done2", {31'b0, cpu_done}, 32'h0);
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0);
      chk("mh_done", {31'b0, cpu_done}, 32'h1);
      chk("mh_err",  {31'b0, cpu_err},  32'h1);
      chk("mh_cyc",  {31'b0, o_wb_cyc}, 32'h0);
      tick();
      issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
      chk("rs_err",  {31'b0, cpu_err},  32'h1);
      chk("rs_cyc",  {31'b0, o_wb_cyc}, 32'h0);
      tick();

      // Reset pulsed while in WAIT; a following ack must be ignored
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
      tick();
      chk("rw_wait_cyc", {31'b0, o_wb_cyc}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rw_cyc", {31'b0, o_wb_cyc}, 32'h0);
      chk("rw_stb", {31'b0, o_wb_stb}, 32'h0);
      chk("rw_re",  {31'b0, o_re},     32'h0);
      chk("rw_we",  {31'b0, o_we},     32'h0);
      #1;
      rst = 1'b0;
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      chk("rw_nodone", {31'b0, cpu_done},  32'h0);
      chk("rw_ready",  {31'b0, cpu_ready}, 32'h1);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0);
      chk("rw2_addr", o_wb_addr, 32'h24);
      i_wb_ack = 1'b1; i_wb_data = 32'h1234_5678;
      tick();
      i_wb_ack = 1'b0;
      chk("rw2_done",  {31'b0, cpu_done}, 32'h1);
      chk("rw2_rdata", cpu_rdata,         32'h1234_5678);
      tick();

`ifdef WB_BUS_TIMEOUT_EN
      // No ack: cyc held for 8 cycles, then an error response
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
      for (int i = 0; i < 7; i++) begin
         chk("to_cyc_hold", {31'b0, o_wb_cyc}, 32'h1);
         tick();
      end
      chk("to_cyc_last", {31'b0, o_wb_cyc}, 32'h1);
      tick();
      chk("to_cyc0",  {31'b0, o_wb_cyc}, 32'h0);
      chk("to_done",  {31'b0, cpu_done}, 32'h1);
      chk("to_err",   {31'b0, cpu_err},  32'h1);
      chk("to_rdata", cpu_rdata,         32'h0);
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
      chk("to_late_done", {31'b0, cpu_done}, 32'h0);
      chk("to_late_cyc",  {31'b0, o_wb_cyc}, 32'h0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
